jtpinpon_obj_linebuf: RTL and testbench

Double-buffered sprite line buffer sitting directly downstream of the object draw engine. While the draw engine writes the next line's pixels into one bank, the other bank is read out at pixel rate using hdump and erased behind the read beam. Banks swap on every hinit. The output feeds the colour mixer as the 4-bit object pixel (0 = transparent).

---
 rtl/jtpinpon_obj_pkg.sv | 13 +
 rtl/jtpinpon_obj_linebuf_if.sv | 24 ++
 rtl/jtpinpon_obj_lbank.sv | 32 +++
 rtl/jtpinpon_obj_linebuf.sv | 152 +++++++++++++++
 tb/tb_jtpinpon_obj_linebuf.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/jtpinpon_obj_pkg.sv
// Shared constants and types for the object line buffer slice.
package jtpinpon_obj_pkg;
   localparam int         OBJ_AW     = 8;
   localparam int         OBJ_DW     = 4;
   localparam logic [3:0] OBJ_TRANSP = 4'd0;

   typedef logic [3:0] obj_pxl_t;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_RMW  = 1'b1
   } wr_state_e;
endpackage

// File: rtl/jtpinpon_obj_linebuf_if.sv
// Video timing, draw-engine write strobe and pixel output of the object line buffer.
interface jtpinpon_obj_linebuf_if #(
   parameter int AW = jtpinpon_obj_pkg::OBJ_AW,
   parameter int DW = jtpinpon_obj_pkg::OBJ_DW
);
   logic          pxl_cen;
   logic          hinit;
   logic          LHBL;
   logic [8:0]    hdump;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] pxl;

   modport master (
      output pxl_cen, hinit, LHBL, hdump, wr_en, wr_addr, wr_data,
      input  pxl
   );

   modport slave (
      input  pxl_cen, hinit, LHBL, hdump, wr_en, wr_addr, wr_data,
      output pxl
   );
endinterface

// File: rtl/jtpinpon_obj_lbank.sv
// One line bank: port A serves draw writes and read-back, port B serves beam read and erase.
module jtpinpon_obj_lbank
   import jtpinpon_obj_pkg::*;
#(
   parameter int AW = OBJ_AW,
   parameter int DW = OBJ_DW
)(
   input  logic          clk,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_din,
   output logic [DW-1:0] a_dout,
   input  logic          b_re,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   output logic [DW-1:0] b_dout
);
   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] a_dout_q;
   logic [DW-1:0] b_dout_q;

   // Contents are deliberately not reset; the erase pass cleans each bank.
   always_ff @(posedge clk) begin
      if (a_we) mem[a_addr] <= a_din;
      if (b_we) mem[b_addr] <= DW'(OBJ_TRANSP);
      a_dout_q <= mem[a_addr];
      if (b_re) b_dout_q <= mem[b_addr];
   end

   assign a_dout = a_dout_q;
   assign b_dout = b_dout_q;
endmodule

// File: rtl/jtpinpon_obj_linebuf.sv
// Double-buffered object line buffer: draw into one bank while the other is scanned and erased.
// Define JTPINPON_OBJBUF_PRIO_EN for first-drawn-wins (read-modify-write) drawing.
module jtpinpon_obj_linebuf
   import jtpinpon_obj_pkg::*;
#(
   parameter int AW = OBJ_AW,
   parameter int DW = OBJ_DW
)(
   input logic                  clk,
   input logic                  rst,
   jtpinpon_obj_linebuf_if.slave bus
);
   logic          line_q,       line_d;
   logic          rd_bank_q,    rd_bank_d;
   logic [DW-1:0] pxl_q,        pxl_d;
   logic          erase_q,      erase_d;
   logic [AW-1:0] erase_addr_q, erase_addr_d;
   logic          erase_bank_q, erase_bank_d;

   logic [AW-1:0] rd_addr;
   logic [AW-1:0] b_addr;
   logic          wr_fire;
   logic          wr_bank;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_din;
   logic [DW-1:0] a_dout [2];
   logic [DW-1:0] b_dout [2];
   logic [8-AW:0] unused_hdump;

   assign rd_addr      = bus.hdump[AW-1:0];
   assign unused_hdump = bus.hdump[8:AW];
   assign b_addr       = erase_q ? erase_addr_q : rd_addr;
   assign bus.pxl      = pxl_q;

   // rd_bank_q remembers which bank's port B holds the sample issued on the last pxl_cen.
   always_comb begin
      line_d       = line_q ^ bus.hinit;
      rd_bank_d    = rd_bank_q;
      pxl_d        = pxl_q;
      erase_d      = bus.pxl_cen & bus.LHBL;
      erase_addr_d = rd_addr;
      erase_bank_d = ~line_q;
      if (bus.pxl_cen) begin
         rd_bank_d = ~line_q;
         pxl_d     = bus.LHBL ? b_dout[rd_bank_q] : DW'(OBJ_TRANSP);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q       <= 1'b0;
         rd_bank_q    <= 1'b0;
         pxl_q        <= '0;
         erase_q      <= 1'b0;
         erase_addr_q <= '0;
         erase_bank_q <= 1'b0;
      end else begin
         line_q       <= line_d;
         rd_bank_q    <= rd_bank_d;
         pxl_q        <= pxl_d;
         erase_q      <= erase_d;
         erase_addr_q <= erase_addr_d;
         erase_bank_q <= erase_bank_d;
      end
   end

`ifdef JTPINPON_OBJBUF_PRIO_EN
   wr_state_e     wr_st_q,   wr_st_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic          wr_bank_q, wr_bank_d;

   // Both banks are read on port A every clk; the RMW stage checks the one it captured.
   always_comb begin
      wr_st_d   = wr_st_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_bank_d = wr_bank_q;
      wr_fire   = 1'b0;
      wr_bank   = wr_bank_q;
      a_addr    = bus.wr_addr;
      a_din     = wr_data_q;
      case (wr_st_q)
         WR_IDLE: begin
            if (bus.wr_en) begin
               wr_st_d   = WR_RMW;
               wr_addr_d = bus.wr_addr;
               wr_data_d = bus.wr_data;
               wr_bank_d = line_q;
            end
         end
         WR_RMW: begin
            a_addr  = wr_addr_q;
            wr_fire = (a_dout[wr_bank_q] == DW'(OBJ_TRANSP)) &&
                      (wr_data_q != DW'(OBJ_TRANSP));
            wr_st_d = WR_IDLE;
         end
         default: wr_st_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_st_q   <= WR_IDLE;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_bank_q <= 1'b0;
      end else begin
         wr_st_q   <= wr_st_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_bank_q <= wr_bank_d;
      end
   end

   a_no_wr_in_rmw: assert property (@(posedge clk) disable iff (rst)
      !((wr_st_q == WR_RMW) && bus.wr_en));
`else
   logic [2*DW-1:0] unused_rdback;

   assign wr_fire       = bus.wr_en && (bus.wr_data != DW'(OBJ_TRANSP));
   assign wr_bank       = line_q;
   assign a_addr        = bus.wr_addr;
   assign a_din         = bus.wr_data;
   assign unused_rdback = {a_dout[1], a_dout[0]};
`endif

   for (genvar i = 0; i < 2; i++) begin : g_bank
      logic sel_wr;
      logic sel_rd;
      logic sel_er;

      assign sel_wr = (wr_bank == 1'(i));
      assign sel_rd = (line_q != 1'(i));
      assign sel_er = (erase_bank_q == 1'(i));

      jtpinpon_obj_lbank #(
         .AW(AW),
         .DW(DW)
      ) u_bank (
         .clk    (clk),
         .a_we   (wr_fire & sel_wr),
         .a_addr (a_addr),
         .a_din  (a_din),
         .a_dout (a_dout[i]),
         .b_re   (bus.pxl_cen & sel_rd),
         .b_we   (erase_q & sel_er),
         .b_addr (b_addr),
         .b_dout (b_dout[i])
      );
   end
endmodule

// File: tb/tb_jtpinpon_obj_linebuf.sv
// Randomised bench for jtpinpon_obj_linebuf with a per-line memory model and directed checks.
module tb_jtpinpon_obj_linebuf;
   import jtpinpon_obj_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   jtpinpon_obj_linebuf_if #(.AW(8), .DW(4)) bus ();

   jtpinpon_obj_linebuf #(.AW(8), .DW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   // Model: two banks of pixel values, -1 meaning "contents not yet defined".
   int mem_m [2][256];
   bit mline;
   int pend_rd;
   int exp_pxl;
   bit er_pend;
   int er_bank;
   int er_addr;
   int ma;

   function automatic void model_write(int b, int ad, int d);
      if (d == 0) return;
`ifdef JTPINPON_OBJBUF_PRIO_EN
      if (mem_m[b][ad] == 0) mem_m[b][ad] = d;
`else
      mem_m[b][ad] = d;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mline   = 1'b0;
         exp_pxl = 0;
         pend_rd = -1;
         er_pend = 1'b0;
         foreach (mem_m[i, j]) mem_m[i][j] = -1;
      end else begin
         ma = int'(bus.hdump[7:0]);
         if (er_pend) mem_m[er_bank][er_addr] = 0;
         er_pend = 1'b0;
         if (bus.wr_en) model_write(int'(mline), int'(bus.wr_addr), int'(bus.wr_data));
         if (bus.pxl_cen) begin
            exp_pxl = bus.LHBL ? pend_rd : 0;
            pend_rd = mem_m[int'(!mline)][ma];
            er_pend = bus.LHBL;
            er_bank = int'(!mline);
            er_addr = ma;
         end
         if (bus.hinit) mline = !mline;
      end
   end

   // Stimulus state: 300 pixels per line, pxl_cen every other clk, blank from 256, hinit at 280.
   int cnt = 290;
   bit ph = 1'b0;
   bit rnd_wr = 1'b0;
   bit prev_wr = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (!rst && exp_pxl >= 0) begin
         tests++;
         if (bus.pxl !== 4'(exp_pxl)) begin
            fails++;
            $display("FAIL model_pxl t=%0t hdump=%0d got=%h exp=%h",
                     $time, bus.hdump, bus.pxl, 4'(exp_pxl));
         end
      end
      @(posedge clk);
      #1;
      if (bus.pxl_cen) cnt = (cnt == 299) ? 0 : cnt + 1;
      ph           = ~ph;
      prev_wr      = bus.wr_en;
      bus.pxl_cen  = ph;
      bus.hdump    = 9'(cnt);
      bus.LHBL     = (cnt < 256);
      bus.hinit    = ph && (cnt == 280);
      bus.wr_en    = 1'b0;
      if (rnd_wr && !prev_wr && $urandom_range(0, 2) == 0) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = 8'($urandom);
         bus.wr_data = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
   endtask

   task automatic wait_line();
      int k = 0;
      do begin tick(); k++; end while (!bus.hinit && k < 1000);
      if (k >= 1000) check("timeout_hinit", 32'd1, 32'd0);
   endtask

   task automatic at_hd(int n);
      int k = 0;
      do begin tick(); k++; end while (!(bus.pxl_cen && bus.hdump == 9'(n)) && k < 1000);
      if (k >= 1000) check("timeout_hdump", 32'(n), 32'hFFFF);
   endtask

   // Advance to the edge that captures the sample issued on the previous pxl_cen.
   task automatic cap_next();
      int k = 0;
      do begin tick(); k++; end while (!bus.pxl_cen && k < 10);
      if (k >= 10) check("timeout_cen", 32'd1, 32'd0);
      tick();
   endtask

   task automatic cap_after(int n);
      at_hd(n);
      cap_next();
   endtask

   task automatic dwrite(int x, int d);
      tick();
      tick();
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'(x);
      bus.wr_data = 4'(d);
   endtask

   initial begin
      int nz;
      rst         = 1'b1;
      bus.pxl_cen = 1'b0;
      bus.hinit   = 1'b0;
      bus.LHBL    = 1'b0;
      bus.hdump   = '0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      repeat (4) tick();
      rst = 1'b0;
      tick();
      check("reset_pxl", 32'(bus.pxl), 32'h0);

      // Idle lines: the third line after reset must be fully transparent.
      wait_line();
      wait_line();
      nz = 0;
      for (int k = 0; k < 1000; k++) begin
         tick();
         if (bus.pxl != 4'h0) nz++;
         if (bus.hinit) break;
      end
      check("idle_line3_nonzero", 32'(nz), 32'd0);

      // Basic write, transparent skip, and erase two lines later.
      dwrite(10, 5);
      dwrite(11, 0);
      wait_line();
      cap_after(10);
      check("pix_x10", 32'(bus.pxl), 32'h5);
      cap_next();
      check("pix_x11_transp", 32'(bus.pxl), 32'h0);
      wait_line();
      wait_line();
      cap_after(10);
      check("erased_x10", 32'(bus.pxl), 32'h0);

      // Overlapping writes at the same x.
      dwrite(20, 3);
      dwrite(20, 9);
      wait_line();
      cap_after(20);
`ifdef JTPINPON_OBJBUF_PRIO_EN
      check("overlap_x20", 32'(bus.pxl), 32'h3);
`else
      check("overlap_x20", 32'(bus.pxl), 32'h9);
`endif

      // Write coincident with hinit lands in the pre-toggle bank.
      wait_line();
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'd30;
      bus.wr_data = 4'h7;
      cap_after(30);
      check("hinit_wr_x30", 32'(bus.pxl), 32'h7);
      wait_line();
      cap_after(30);
      check("hinit_wr_next_line", 32'(bus.pxl), 32'h0);

      // Blanked pixel at 255 and a wrapped write address.
      dwrite(255, 10);
      dwrite(256, 12);
      wait_line();
      cap_after(0);
      check("wrap_x0", 32'(bus.pxl), 32'hC);
      cap_after(255);
      check("blank_x255", 32'(bus.pxl), 32'h0);

      // Random drawing checked against the model.
      rnd_wr = 1'b1;
      repeat (6) wait_line();

      // Mid-line reset pulse.
      at_hd(100);
      #2;
      rst = 1'b1;
      #1;
      check("rst_pxl_now", 32'(bus.pxl), 32'h0);
      tick();
      rst = 1'b0;
      repeat (4) wait_line();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
